// File: rtl/dvp_capture.sv
// DVP camera capture: assembles bus words into pixels, skips the first
// PIC_WAIT frames, applies a per-frame crop window and tags SOF/EOL/EOF.
module dvp_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int PIC_WAIT      = 10,
  parameter int H_ACTIVE      = 640,
  parameter int COORD_W       = 12,
  parameter int BYTE_SWAP     = 0
) (
  input  logic                              cam_pclk,
  input  logic                              sys_rst,
  input  logic                              cam_href,
  input  logic                              cam_vsync,
  input  logic [DATA_W-1:0]                 cam_data,
  input  logic                              cap_en,
  input  logic [COORD_W-1:0]                crop_x0,
  input  logic [COORD_W-1:0]                crop_y0,
  input  logic [COORD_W-1:0]                crop_w,
  input  logic [COORD_W-1:0]                crop_h,
  output logic                              pix_valid,
  output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data,
  output logic                              pix_sof,
  output logic                              pix_eol,
  output logic                              pix_eof,
  output logic                              line_err,
  output logic [15:0]                       frame_cnt
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam int BC_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int CP_W  = (PIC_WAIT > 0) ? $clog2(PIC_WAIT + 1) : 1;
  localparam logic [BC_W-1:0]    BC_LAST = BC_W'(BYTES_PER_PIX - 1);
  localparam logic [BC_W-1:0]    BC_ONE  = BC_W'(1);
  localparam logic [CP_W-1:0]    PIC_MAX = CP_W'(PIC_WAIT);
  localparam logic [CP_W-1:0]    CP_ONE  = CP_W'(1);
  localparam logic [COORD_W-1:0] H_LEN   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [COORD_W:0]   E_ONE   = (COORD_W+1)'(1);

  logic                vsync_d_q, vsync_d_d, href_d_q, href_d_d;
  logic [CP_W-1:0]     cnt_pic_q, cnt_pic_d;
  logic                pic_valid_q, pic_valid_d, frame_act_q, frame_act_d;
  logic                eof_exp_q, eof_exp_d, eof_done_q, eof_done_d;
  logic [COORD_W-1:0]  cx0_q, cx0_d, cy0_q, cy0_d, cw_q, cw_d, ch_q, ch_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [PIX_W-1:0]    pix_data_q, pix_data_d;
  logic                line_err_q, line_err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic             vs_rise, href_fall, pix_done, in_win, at_eol, at_eof, emit;
  logic [COORD_W:0] xe, ye, x_end, y_end;
  logic [PIX_W-1:0] asm_w;

  // Word accumulator: holds the earlier words of the pixel being assembled.
  generate
    if (BYTES_PER_PIX == 1) begin : g_asm1
      assign asm_w = cam_data;
    end else begin : g_asmn
      localparam int ACC_W = PIX_W - DATA_W;
      logic [ACC_W-1:0] acc_q, acc_d;
      if (BYTE_SWAP == 0) begin : g_msb_first
        assign asm_w = {acc_q, cam_data};
      end else begin : g_lsb_first
        assign asm_w = {cam_data, acc_q};
      end
      // Shift the new word in while href is high.
      always_comb begin
        acc_d = acc_q;
        if (cam_href) acc_d = (BYTE_SWAP == 0) ? asm_w[ACC_W-1:0] : asm_w[PIX_W-1:DATA_W];
      end
      // Accumulator register.
      always_ff @(posedge cam_pclk) begin
        if (sys_rst) acc_q <= '0;
        else         acc_q <= acc_d;
      end
    end
  endgenerate

  // Frame/line sequencing, window test and output staging.
  always_comb begin
    vsync_d_d   = cam_vsync;
    href_d_d    = cam_href;
    cnt_pic_d   = cnt_pic_q;
    pic_valid_d = pic_valid_q;
    frame_act_d = frame_act_q;
    eof_exp_d   = eof_exp_q;
    eof_done_d  = eof_done_q;
    cx0_d = cx0_q; cy0_d = cy0_q; cw_d = cw_q; ch_d = ch_q;
    x_d = x_q; y_d = y_q;
    byte_cnt_d  = byte_cnt_q;
    pix_data_d  = pix_data_q;
    frame_cnt_d = frame_cnt_q;

    vs_rise   = cam_vsync & ~vsync_d_q;
    href_fall = href_d_q & ~cam_href;
    pix_done  = cam_href & (byte_cnt_q == BC_LAST);

    // Widened compares so origin+size never wraps.
    xe     = {1'b0, x_q};
    ye     = {1'b0, y_q};
    x_end  = {1'b0, cx0_q} + {1'b0, cw_q};
    y_end  = {1'b0, cy0_q} + {1'b0, ch_q};
    in_win = (xe >= {1'b0, cx0_q}) && (xe < x_end) && (ye >= {1'b0, cy0_q}) && (ye < y_end);
    at_eol = (xe + E_ONE) == x_end;
    at_eof = at_eol && ((ye + E_ONE) == y_end);

    // A pixel finishing on the vsync edge belongs to the abandoned frame.
    emit        = frame_act_q & pix_done & in_win & ~vs_rise;
    pix_valid_d = emit;
    sof_d       = emit & (x_q == cx0_q) & (y_q == cy0_q);
    eol_d       = emit & at_eol;
    eof_d       = emit & at_eof;
    if (emit) pix_data_d = asm_w;
    if (emit && at_eof) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      eof_done_d  = 1'b1;
    end

    line_err_d = href_fall && ((byte_cnt_q != '0) || (x_q != H_LEN));

    if (vs_rise) begin
      if (frame_act_q && eof_exp_q && !eof_done_q) line_err_d = 1'b1;
      if (cnt_pic_q != PIC_MAX) cnt_pic_d = cnt_pic_q + CP_ONE;
      pic_valid_d = pic_valid_q | (cnt_pic_q == PIC_MAX);
      frame_act_d = pic_valid_d & cap_en;
      eof_exp_d   = frame_act_d && (crop_w != '0) && (crop_h != '0);
      eof_done_d  = 1'b0;
      cx0_d = crop_x0; cy0_d = crop_y0; cw_d = crop_w; ch_d = crop_h;
      x_d = '0; y_d = '0; byte_cnt_d = '0;
    end else if (href_fall) begin
      if (x_q != '0) y_d = y_q + C_ONE;
      x_d = '0;
      byte_cnt_d = '0;
    end else if (cam_href) begin
      byte_cnt_d = (byte_cnt_q == BC_LAST) ? '0 : byte_cnt_q + BC_ONE;
      if (pix_done) x_d = x_q + C_ONE;
    end else begin
      byte_cnt_d = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge cam_pclk) begin
    if (sys_rst) begin
      vsync_d_q <= 1'b0; href_d_q <= 1'b0; cnt_pic_q <= '0;
      pic_valid_q <= 1'b0; frame_act_q <= 1'b0; eof_exp_q <= 1'b0; eof_done_q <= 1'b0;
      cx0_q <= '0; cy0_q <= '0; cw_q <= '0; ch_q <= '0;
      x_q <= '0; y_q <= '0; byte_cnt_q <= '0;
      pix_valid_q <= 1'b0; pix_data_q <= '0; sof_q <= 1'b0; eol_q <= 1'b0; eof_q <= 1'b0;
      line_err_q <= 1'b0; frame_cnt_q <= '0;
    end else begin
      vsync_d_q <= vsync_d_d; href_d_q <= href_d_d; cnt_pic_q <= cnt_pic_d;
      pic_valid_q <= pic_valid_d; frame_act_q <= frame_act_d; eof_exp_q <= eof_exp_d;
      eof_done_q <= eof_done_d;
      cx0_q <= cx0_d; cy0_q <= cy0_d; cw_q <= cw_d; ch_q <= ch_d;
      x_q <= x_d; y_q <= y_d; byte_cnt_q <= byte_cnt_d;
      pix_valid_q <= pix_valid_d; pix_data_q <= pix_data_d;
      sof_q <= sof_d; eol_q <= eol_d; eof_q <= eof_d;
      line_err_q <= line_err_d; frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_sof   = sof_q;
  assign pix_eol   = eol_q;
  assign pix_eof   = eof_q;
  assign line_err  = line_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench for dvp_capture: two instances (MS-first and LS-first)
// share the stimulus; the driver pushes expected pixels, a monitor pops them.
module tb_dvp_capture;
  localparam int DW = 8, BPP = 2, PW = 2, HA = 8, CW = 4;

  logic          clk = 1'b0, sys_rst = 1'b1;
  logic          cam_href = 1'b0, cam_vsync = 1'b0, cap_en = 1'b0;
  logic [DW-1:0] cam_data = '0;
  logic [CW-1:0] crop_x0 = '0, crop_y0 = '0, crop_w = '0, crop_h = '0;
  logic          pv0, sof0, eol0, eof0, le0, pv1, sof1, eol1, eof1, le1;
  logic [15:0]   pd0, pd1, fc0, fc1;

  always #5 clk = ~clk;

  dvp_capture #(.DATA_W(DW), .BYTES_PER_PIX(BPP), .PIC_WAIT(PW), .H_ACTIVE(HA),
                .COORD_W(CW), .BYTE_SWAP(0)) u_msb (
    .cam_pclk(clk), .sys_rst(sys_rst), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .cap_en(cap_en), .crop_x0(crop_x0), .crop_y0(crop_y0),
    .crop_w(crop_w), .crop_h(crop_h), .pix_valid(pv0), .pix_data(pd0), .pix_sof(sof0),
    .pix_eol(eol0), .pix_eof(eof0), .line_err(le0), .frame_cnt(fc0));

  dvp_capture #(.DATA_W(DW), .BYTES_PER_PIX(BPP), .PIC_WAIT(PW), .H_ACTIVE(HA),
                .COORD_W(CW), .BYTE_SWAP(1)) u_lsb (
    .cam_pclk(clk), .sys_rst(sys_rst), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .cap_en(cap_en), .crop_x0(crop_x0), .crop_y0(crop_y0),
    .crop_w(crop_w), .crop_h(crop_h), .pix_valid(pv1), .pix_data(pd1), .pix_sof(sof1),
    .pix_eol(eol1), .pix_eof(eof1), .line_err(le1), .frame_cnt(fc1));

  typedef struct {
    logic [15:0] d;
    logic        sof, eol, eof;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   nvs = 0, exp_fc = 0, exp_le = 0, le_cnt = 0;
  bit   cur_act = 0, pend = 0;
  int   cx0 = 0, cy0 = 0, cw = 0, ch = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference window model: decides whether pixel (x,y) is expected and its tags.
  task automatic push_pix(input int x, input int y, input logic [7:0] hi, input logic [7:0] lo);
    exp_t e;
    if (cur_act && x >= cx0 && x < cx0 + cw && y >= cy0 && y < cy0 + ch) begin
      e.d   = {hi, lo};
      e.sof = (x == cx0) && (y == cy0);
      e.eol = (x == cx0 + cw - 1);
      e.eof = e.eol && (y == cy0 + ch - 1);
      if (e.eof) begin
        exp_fc = (exp_fc + 1) & 16'hffff;
        pend   = 0;
      end
      e.fc = 16'(exp_fc);
      q.push_back(e);
    end
  endtask

  task automatic vs_start(input int x0, input int y0, input int w, input int h, input bit cap);
    bit e;
    @(negedge clk);
    crop_x0 = CW'(x0); crop_y0 = CW'(y0); crop_w = CW'(w); crop_h = CW'(h);
    cap_en = cap; cam_vsync = 1'b1; cam_href = 1'b0;
    e = pend;
    @(negedge clk);
    chk("vs_missing_eof_err", le0, e);
    if (e) exp_le++;
    nvs++;
    cur_act = (nvs > PW) && cap;
    cx0 = x0; cy0 = y0; cw = w; ch = h;
    pend = cur_act && w > 0 && h > 0;
    @(negedge clk); cam_vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One href line of 'words' bus words; 'cut' raises vsync on one extra word
  // that would have completed the next pixel.
  task automatic line(input int y, input int words, input bit cut);
    logic [7:0] hi, lo;
    bit e;
    for (int i = 0; i < words; i++) begin
      hi = 8'(8'hA5 ^ (y * 16 + i / 2));
      lo = 8'(8'h3C ^ ((i / 2) * 16 + y));
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = (i % 2 == 0) ? hi : lo;
      if (i % 2 == 1) push_pix(i / 2, y, hi, lo);
    end
    if (cut) begin
      @(negedge clk); cam_href = 1'b1; cam_data = 8'h77; cam_vsync = 1'b1;
      @(negedge clk); cam_href = 1'b0;
      chk("cut_vs_err", le0, 1'(pend));
      if (pend) exp_le++;
      @(negedge clk); cam_vsync = 1'b0;
      chk("cut_fall_err", le0, 1'b1);
      exp_le++;
      nvs++;
      cur_act = (nvs > PW) && cap_en;
      pend = cur_act && cw > 0 && ch > 0;
    end else begin
      @(negedge clk); cam_href = 1'b0;
      @(negedge clk);
      e = (words != 2 * HA);
      chk("line_end_err", le0, e);
      if (e) exp_le++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic body(input int last_words);
    for (int y = 0; y < 4; y++) line(y, (y == 3) ? last_words : 2 * HA, 1'b0);
    chk("frame_drained", q.size(), 0);
  endtask

  // Monitor: every presented pixel is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (le0 === 1'b1) le_cnt++;
      if (pv0 === 1'b1) begin
        if (q.size() == 0) chk("unexpected_pix", pv0, 1'b0);
        else begin
          e = q.pop_front();
          chk("pix_data", pd0, e.d);
          chk("pix_sof", sof0, e.sof);
          chk("pix_eol", eol0, e.eol);
          chk("pix_eof", eof0, e.eof);
          chk("frame_cnt", fc0, e.fc);
          chk("swap_valid", pv1, 1'b1);
          chk("swap_data", pd1, {e.d[7:0], e.d[15:8]});
        end
      end else if (pv1 === 1'b1) chk("swap_stray", pv1, 1'b0);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", pv0, 1'b0); chk("rst_data", pd0, 16'h0); chk("rst_sof", sof0, 1'b0);
    chk("rst_eol", eol0, 1'b0); chk("rst_eof", eof0, 1'b0); chk("rst_lerr", le0, 1'b0);
    chk("rst_fcnt", fc0, 16'h0);
    sys_rst = 1'b0;

    // Two discarded frames, then a full frame.
    for (int f = 0; f < 3; f++) begin vs_start(0, 0, 8, 4, 1'b1); body(16); end
    chk("fcnt_after_full", fc0, 16'd1);
    // Crop 2,1,3,2.
    vs_start(2, 1, 3, 2, 1'b1); body(16);
    chk("fcnt_after_crop", fc0, 16'd2);
    // Short last line: line_err, no EOF.
    vs_start(0, 0, 8, 4, 1'b1); body(15);
    chk("fcnt_short_frame", fc0, 16'd2);
    // cap_en low at frame start, raised mid-frame.
    vs_start(0, 0, 8, 4, 1'b0);
    line(0, 16, 1'b0); cap_en = 1'b1;
    for (int y = 1; y < 4; y++) line(y, 16, 1'b0);
    chk("fcnt_capoff", fc0, 16'd2);
    // Capture resumes, then vsync cuts line 1 mid-pixel; the new frame runs in full.
    vs_start(0, 0, 8, 4, 1'b1);
    line(0, 16, 1'b0); line(1, 5, 1'b1);
    body(16);
    chk("fcnt_after_cut", fc0, 16'd3);
    // Zero-width window: nothing emitted and no missing-EOF error later.
    vs_start(0, 0, 0, 4, 1'b1); body(16);
    // Reset in the middle of a frame.
    vs_start(0, 0, 8, 4, 1'b1);
    line(0, 16, 1'b0); line(1, 16, 1'b0);
    chk("pre_rst_fcnt", fc0, 16'd3);
    @(negedge clk); sys_rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", pv0, 1'b0); chk("midrst_data", pd0, 16'h0);
    chk("midrst_fcnt", fc0, 16'h0); chk("midrst_lerr", le0, 1'b0);
    sys_rst = 1'b0;
    nvs = 0; exp_fc = 0; pend = 0; cur_act = 0; q.delete();
    for (int f = 0; f < 3; f++) begin vs_start(0, 0, 8, 4, 1'b1); body(16); end
    chk("fcnt_after_rst", fc0, 16'd1);
    vs_start(0, 0, 8, 4, 1'b1);
    repeat (4) @(negedge clk);
    chk("lerr_pulses", le_cnt, exp_le);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
